us_delay_timer: RTL and testbench

//  Programmable delay/timeout counter clocked by the free-running 1 us toggle

---
 rtl/us_delay_timer_pkg.sv | 13 +
 rtl/us_delay_timer_edge.sv | 22 ++
 rtl/us_delay_timer.sv | 114 +++++++++++
 tb/tb_us_delay_timer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/us_delay_timer_pkg.sv
// Shared types and unit constants for the microsecond delay timer.
// Imported by the timer top and by timebase consumers.
package us_delay_timer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int PRESC_US = 1;
  localparam int PRESC_MS = 1000;

endpackage

// File: rtl/us_delay_timer_edge.sv
// Toggle-to-pulse edge detector for timebase toggle outputs.
// Both polarities of the toggle produce a one-cycle pulse.
module tgl_edge_det (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic tgl_i,
  output logic edge_o
);

  logic tgl_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tgl_q <= 1'b0;
    end else begin
      tgl_q <= tgl_i;
    end
  end

  assign edge_o = tgl_q ^ tgl_i;

endmodule

// File: rtl/us_delay_timer.sv
// Programmable one-shot / periodic delay counter driven by the 1 us toggle.
// Counts PRESC toggle edges per unit and pulses done_o on expiry.
module us_delay_timer
  import us_delay_timer_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int PRESC = PRESC_US,
  parameter int PRE_W = 10
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             tick_tgl_i,
  input  logic             start_i,
  input  logic             cancel_i,
  input  logic             periodic_i,
  input  logic [CNT_W-1:0] dly_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] remain_o
);

  localparam logic [PRE_W-1:0] PreLast = PRE_W'(PRESC - 1);

  state_e           state_q, state_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic             per_q, per_d;
  logic             done_q, done_d;
  logic             edge_w, unit_w, expire_w;

  tgl_edge_det u_edge (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .tgl_i   (tick_tgl_i),
    .edge_o  (edge_w)
  );

  assign unit_w   = (state_q == ST_RUN) && edge_w && (presc_q == PreLast);
  assign expire_w = unit_w && (remain_q <= CNT_W'(1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (cancel_i) begin
      state_d = ST_IDLE;
    end else if (start_i) begin
      state_d = (dly_i != '0) ? ST_RUN : ST_IDLE;
    end else if (expire_w && !per_q) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    presc_d  = presc_q;
    remain_d = remain_q;
    reload_d = reload_q;
    per_d    = per_q;
    done_d   = 1'b0;
    if (cancel_i) begin
      presc_d  = '0;
      remain_d = '0;
    end else if (start_i) begin
      presc_d  = '0;
      remain_d = dly_i;
      reload_d = dly_i;
      per_d    = periodic_i;
      // zero delay expires at once and never reloads
      done_d   = (dly_i == '0);
    end else if (state_q == ST_RUN && edge_w) begin
      if (unit_w) begin
        presc_d = '0;
        if (expire_w) begin
          done_d   = 1'b1;
          remain_d = per_q ? reload_q : '0;
        end else begin
          remain_d = remain_q - CNT_W'(1);
        end
      end else begin
        presc_d = presc_q + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      presc_q  <= '0;
      remain_q <= '0;
      reload_q <= '0;
      per_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      remain_q <= remain_d;
      reload_q <= reload_d;
      per_q    <= per_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    busy_o   = (state_q == ST_RUN);
    done_o   = done_q;
    remain_o = remain_q;
  end

endmodule

// File: tb/tb_us_delay_timer.sv
// Scoreboard bench for us_delay_timer: directed vectors, done_o events
// checked by per-instance monitors against queued expectations.
module tb_us_delay_timer;

  typedef struct {
    int         cyc;
    logic       busy;
    logic [15:0] rem;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        t1 = 1'b1, s1 = 1'b0, c1 = 1'b0, p1 = 1'b0;
  logic [15:0] d1 = '0;
  logic        b1_o, dn1_o;
  logic [15:0] r1_o;

  logic        t4 = 1'b0, s4 = 1'b0, c4 = 1'b0, p4 = 1'b0;
  logic [15:0] d4 = '0;
  logic        b4_o, dn4_o;
  logic [15:0] r4_o;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  exp_t q1[$];
  exp_t q4[$];

  us_delay_timer #(.CNT_W(16), .PRESC(1), .PRE_W(10)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .tick_tgl_i(t1),
    .start_i(s1), .cancel_i(c1), .periodic_i(p1), .dly_i(d1),
    .busy_o(b1_o), .done_o(dn1_o), .remain_o(r1_o)
  );

  us_delay_timer #(.CNT_W(16), .PRESC(4), .PRE_W(10)) u_dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .tick_tgl_i(t4),
    .start_i(s4), .cancel_i(c4), .periodic_i(p4), .dly_i(d4),
    .busy_o(b4_o), .done_o(dn4_o), .remain_o(r4_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic mon_pop(input string nm, inout exp_t q[$],
                         input logic b, input logic [15:0] r);
    exp_t e;
    if (q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_unexp_done: got done at cyc %0d expected none",
               nm, cyc);
    end else begin
      e = q.pop_front();
      chk({nm, "_done_cyc"}, cyc, e.cyc);
      chk({nm, "_done_busy"}, int'(b), int'(e.busy));
      chk({nm, "_done_rem"}, int'(r), int'(e.rem));
    end
  endtask

  always @(negedge clk) if (dn1_o) mon_pop("d1", q1, b1_o, r1_o);
  always @(negedge clk) if (dn4_o) mon_pop("d4", q4, b4_o, r4_o);

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic push1(input logic b, input logic [15:0] r);
    exp_t e;
    e.cyc = cyc + 1; e.busy = b; e.rem = r;
    q1.push_back(e);
  endtask

  task automatic push4(input logic b, input logic [15:0] r);
    exp_t e;
    e.cyc = cyc + 1; e.busy = b; e.rem = r;
    q4.push_back(e);
  endtask

  logic b4_low;

  initial begin
    // reset with tick held high
    repeat (3) nxt();
    rst_n = 1'b1;
    repeat (3) nxt();
    chk("rst_busy", int'(b1_o), 0);
    chk("rst_rem", int'(r1_o), 0);
    chk("rst_done", int'(dn1_o), 0);

    // A: PRESC=1 one-shot dly=3
    s1 = 1'b1; d1 = 16'd3; p1 = 1'b0;
    nxt();
    s1 = 1'b0;
    chk("A_busy0", int'(b1_o), 1);
    chk("A_rem3", int'(r1_o), 3);
    t1 = ~t1; nxt();
    chk("A_rem2", int'(r1_o), 2);
    t1 = ~t1; nxt();
    chk("A_rem1", int'(r1_o), 1);
    push1(1'b0, 16'd0);
    t1 = ~t1; nxt();
    chk("A_busy_end", int'(b1_o), 0);
    nxt();
    chk("A_rem_end", int'(r1_o), 0);

    // C: zero delay
    s1 = 1'b1; d1 = 16'd0;
    push1(1'b0, 16'd0);
    nxt();
    s1 = 1'b0;
    chk("C_busy", int'(b1_o), 0);
    nxt();
    chk("C_busy2", int'(b1_o), 0);

    // D: cancel together with start at remain=1
    s1 = 1'b1; d1 = 16'd2;
    nxt();
    s1 = 1'b0;
    t1 = ~t1; nxt();
    chk("D_rem1", int'(r1_o), 1);
    c1 = 1'b1; s1 = 1'b1; d1 = 16'd7; t1 = ~t1;
    nxt();
    c1 = 1'b0; s1 = 1'b0;
    chk("D_busy", int'(b1_o), 0);
    chk("D_rem0", int'(r1_o), 0);
    repeat (4) begin t1 = ~t1; nxt(); end
    chk("D_rem_idle", int'(r1_o), 0);

    // E: restart on the expiring edge
    s1 = 1'b1; d1 = 16'd2;
    nxt();
    s1 = 1'b0;
    t1 = ~t1; nxt();
    chk("E_rem1", int'(r1_o), 1);
    s1 = 1'b1; d1 = 16'd5; t1 = ~t1;
    nxt();
    s1 = 1'b0;
    chk("E_rem5", int'(r1_o), 5);
    chk("E_busy", int'(b1_o), 1);
    for (int i = 4; i >= 1; i--) begin
      t1 = ~t1; nxt();
      chk("E_cnt", int'(r1_o), i);
    end
    push1(1'b0, 16'd0);
    t1 = ~t1; nxt();
    chk("E_busy_end", int'(b1_o), 0);

    // B: PRESC=4 periodic dly=2, three periods
    s4 = 1'b1; d4 = 16'd2; p4 = 1'b1;
    nxt();
    s4 = 1'b0;
    b4_low = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      if (k % 8 == 0) push4(1'b1, 16'd2);
      t4 = ~t4; nxt();
      if (!b4_o) b4_low = 1'b1;
      if (k == 4) chk("B_rem1", int'(r4_o), 1);
      if (k == 7) chk("B_rem1b", int'(r4_o), 1);
    end
    chk("B_busy_held", int'(b4_low), 0);
    chk("B_rem_reload", int'(r4_o), 2);
    c4 = 1'b1;
    nxt();
    c4 = 1'b0;
    chk("B_cancel_busy", int'(b4_o), 0);
    chk("B_cancel_rem", int'(r4_o), 0);

    repeat (4) nxt();
    chk("sb_q1_left", q1.size(), 0);
    chk("sb_q4_left", q4.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
